add_stim_checker: RTL
=====================

Name: add_stim_checker

Overview:
- Initiator/checker for the 16-bit adder DUT interface (operands A, B in; sum C out).
- Drives operand pairs onto A/B, waits a programmable settle time, samples C and compares it against the modulo-2^WIDTH sum.
- Reports error count, first failing vector and pass/done status.
- Sits in the testbench top beside the adder DUT, replacing VPI-driven stimulus with self-contained RTL stimulus.

Parameters:
- WIDTH, 16: operand/sum width; legal range 1..16.
- SETTLE, 2: cycles between driving operands and sampling c_in; must be >=1.
- NUM_VECTORS, 256: vectors per run; legal range 1..65535.
- SEED, 32'hACE1_0001: LFSR reload value; must be nonzero.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE or DONE.
- a_out  out  WIDTH  operand A to DUT.
- b_out  out  WIDTH  operand B to DUT.
- c_in  in  WIDTH  sum from DUT.
- busy  out  1  run in progress.
- done  out  1  run complete; held until next start.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- vec_count  out  16  vectors checked this run.
- err_count  out  16  mismatches this run; saturates at 16'hFFFF.
- fail_idx  out  16  index of first mismatching vector.
- fail_c  out  WIDTH  c_in captured at first mismatch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lfsr=SEED; all outputs 0.
- Operand source is a 32-bit Galois LFSR, taps 32'h8020_0003, shifting right; feedback taken from bit 0.
  - Vector 0 is fixed: A=all ones, B=1 (wrap-around case).
  - Vector k>=1: A=lfsr[WIDTH-1:0], B=lfsr[31:32-WIDTH], with the LFSR advanced once before each vector k>=1 is driven.
- exp = (a_out + b_out) truncated to WIDTH bits; carry discarded. It is registered at drive time.
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE + start=1 at edge:
  - Clear vec_count, err_count, fail_idx, fail_c, done, pass; lfsr=SEED.
  - Drive vector 0; cnt=SETTLE-1; busy=1; go to WAIT.
- WAIT: a_out/b_out held stable. If cnt==0, go to CHECK; else cnt--.
- CHECK (one cycle): compare c_in to exp.
  - On mismatch: err_count++ (saturating). If this is the first mismatch, latch fail_idx=vec_count and fail_c=c_in.
  - vec_count++.
  - If the new vec_count==NUM_VECTORS: go to DONE, busy=0, done=1, pass=(final err_count==0).
  - Otherwise: advance the LFSR, drive the next vector, cnt=SETTLE-1, go to WAIT.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done rises at the edge NUM_VECTORS*(SETTLE+1) after the start edge (768 with defaults).
- start while busy=1 is ignored; there are no side effects.
- a_out/b_out keep the last vector in DONE and return to 0 only on reset.
- Reset mid-run aborts immediately to reset values. A later start restarts from vector 0 with an identical sequence.
- Outputs are registered; there are no combinational paths from c_in to any output.

Test Plan:
- Reset, then start with a correct adder DUT (C<=A+B) and defaults.
  - Required: a_out=16'hFFFF and b_out=16'h0001 one cycle after start.
  - Required: the first check sees c_in=16'h0000.
  - Required: done=1 at cycle 768, vec_count=256, err_count=0, pass=1.
- Faulty DUT forcing C=A+B+1 only when A=16'hFFFF.
  - Required: err_count>=1, fail_idx=0, fail_c=16'h0001, pass=0.
- Stuck DUT with c_in tied to 0, NUM_VECTORS=4.
  - Required: err_count=3 (vector 0 passes, vectors 1-3 fail), fail_idx=1.
- Pulse start while busy, at cycle 100.
  - Required: no restart, vec_count continues monotonically, done still at cycle 768.
- Deassert rst_n at cycle 50 of a run, release it, then start again.
  - Required: all outputs 0 during reset.
  - Required: the second run's a_out/b_out sequence matches the first run's sequence bit-for-bit.
- SETTLE=1, NUM_VECTORS=1, WIDTH=8.
  - Required: a_out=8'hFF, b_out=8'h01, done at cycle 2, vec_count=1, pass=1.

Source files
------------

// File: rtl/add_stim_checker.sv
// Self-contained stimulus generator and checker for a WIDTH-bit adder:
// drives LFSR operand pairs, waits SETTLE cycles, compares the sum and reports the first failure.
module add_stim_checker #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned NUM_VECTORS = 256,
    parameter logic [31:0] SEED        = 32'hACE1_0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] c_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [15:0]      err_count,
    output logic [15:0]      fail_idx,
    output logic [WIDTH-1:0] fail_c
);

    localparam logic [31:0]     TAPS     = 32'h8020_0003;
    localparam int unsigned     CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [15:0]     LAST_VEC = 16'(NUM_VECTORS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, exp_q, exp_d, fail_c_q, fail_c_d;
    logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0]      vec_q, vec_d, err_q, err_d, fail_idx_q, fail_idx_d;

    logic [31:0]      lfsr_nxt;
    logic [15:0]      vec_nxt, err_nxt;

    // Galois right-shift step; feedback is the bit shifted out of position 0
    assign lfsr_nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 32'h0);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        exp_d      = exp_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        vec_d      = vec_q;
        err_d      = err_q;
        fail_idx_d = fail_idx_q;
        fail_c_d   = fail_c_q;
        vec_nxt    = vec_q + 16'd1;
        err_nxt    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    vec_d      = '0;
                    err_d      = '0;
                    fail_idx_d = '0;
                    fail_c_d   = '0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    lfsr_d     = SEED;
                    // Vector 0 exercises wrap-around: all-ones + 1 == 0
                    a_d        = '1;
                    b_d        = WIDTH'(1);
                    exp_d      = '0;
                    cnt_d      = CNT_LOAD;
                    busy_d     = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (c_in != exp_q) begin
                    if (err_q != 16'hFFFF) begin
                        err_nxt = err_q + 16'd1;
                    end
                    if (err_q == 16'h0000) begin
                        fail_idx_d = vec_q;
                        fail_c_d   = c_in;
                    end
                end
                err_d = err_nxt;
                vec_d = vec_nxt;
                if (vec_nxt == LAST_VEC) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_nxt == 16'h0000);
                    state_d = S_DONE;
                end else begin
                    lfsr_d  = lfsr_nxt;
                    a_d     = lfsr_nxt[WIDTH-1:0];
                    b_d     = lfsr_nxt[31 -: WIDTH];
                    exp_d   = lfsr_nxt[WIDTH-1:0] + lfsr_nxt[31 -: WIDTH];
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= SEED;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            exp_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            vec_q      <= '0;
            err_q      <= '0;
            fail_idx_q <= '0;
            fail_c_q   <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            a_q        <= a_d;
            b_q        <= b_d;
            exp_q      <= exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            fail_idx_q <= fail_idx_d;
            fail_c_q   <= fail_c_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign vec_count = vec_q;
    assign err_count = err_q;
    assign fail_idx  = fail_idx_q;
    assign fail_c    = fail_c_q;

endmodule
